rd_req_arbiter: RTL and testbench
=================================

# rd_req_arbiter

Round-robin arbiter that shares one downstream read-address channel among `SRC_NUM` read-request FIFOs of the cross-bar. It pops one request at a time through the FIFO's `req`/`addr`/`rd_en` signals and forwards it as a valid/ready address beat tagged with the source index. It holds the channel until the read completes (`rd_done`) or a watchdog expires, then re-arbitrates. There is one instance per cross-bar master port.

## Interface
Parameters:
- `AWIDTH`, 32, address width
- `SRC_NUM`, 2, number of requesting FIFOs (≥2)
- `IDW`, `$clog2(SRC_NUM)`, width of source tag
- `TIMEOUT`, 256, max cycles in WAIT before abort (≥1)

Ports:
- `aclk` in 1: the single clock; all logic is rising-edge.
- `areset` in 1: reset, synchronous, active-high.
- `req` in `SRC_NUM`: per-FIFO not-empty; the FIFO is first-word-fall-through.
- `addr` in `SRC_NUM*AWIDTH`: head-of-FIFO addresses; source i occupies slice `[i*AWIDTH +: AWIDTH]`.
- `rd_en` out `SRC_NUM`: one-cycle pop strobe, one-hot or zero.
- `m_arvalid` out 1: downstream address valid.
- `m_araddr` out `AWIDTH`: downstream address.
- `m_arid` out `IDW`: index of the granted source.
- `m_arready` in 1: downstream accept.
- `rd_done` in 1: last read-data beat of the outstanding request returned.
- `busy` out 1: high whenever state ≠ IDLE.
- `timeout_err` out 1: one-cycle pulse on watchdog abort.

## Operation
- Uses a 3-state FSM: IDLE, ISSUE, WAIT.
- **IDLE**
  - The winner is the first set `req` bit searching upward from `ptr`, wrapping modulo `SRC_NUM`.
  - If any `req` is set, the next edge does the following:
    - register `grant_idx` = winner;
    - register `addr_q` = winner's slice;
    - pulse `rd_en[winner]`;
    - go to ISSUE.
- **ISSUE**
  - Drive `m_arvalid`=1, `m_araddr`=`addr_q`, `m_arid`=`grant_idx`.
  - `rd_en` is high only in the first ISSUE cycle.
  - Address and id stay stable until `m_arready`.
  - On `m_arvalid`&&`m_arready`: go to WAIT and clear the watchdog counter.
- **WAIT**
  - `m_arvalid`=0. The counter increments each cycle.
  - On `rd_done`: go to IDLE and set `ptr` = `grant_idx`+1, wrapping `SRC_NUM-1`→0.
  - If the counter reaches `TIMEOUT-1` without `rd_done`: pulse `timeout_err`, go to IDLE, and advance `ptr` the same way.
- `rd_done` outside WAIT is ignored.
- `rd_done` coinciding with the timeout cycle counts as a normal completion: no error is raised.
- `req` changes in ISSUE or WAIT have no effect.
- `ptr` changes only on leaving WAIT.
- Counter width is `$clog2(TIMEOUT+1)`. It saturates and never wraps.

## Timing
- Reset values apply on the first edge with `areset`=1:
  - state IDLE, `ptr`=0;
  - `rd_en`=0, `m_arvalid`=0, `m_araddr`=0, `m_arid`=0;
  - `busy`=0, `timeout_err`=0.
- Reset mid-ISSUE or mid-WAIT abandons the transaction. No pop or error is emitted.
- All outputs are registered.
- `req` at cycle N gives `rd_en` and `m_arvalid` at N+1.
- `m_arvalid` is held through backpressure. With `m_arready` already high at N+1, WAIT starts at N+2.
- `rd_done` at cycle D gives IDLE at D+1. Pending `req` then gives the next `m_arvalid` at D+2. Minimum grant period is 3 cycles plus read latency.
- Exactly one `rd_en` pulse per grant. It is never asserted while the granted source's `req` is 0.

## Structure
- Shared package `xbar_pkg` holds:
  - the `arb_state_e` enum (IDLE, ISSUE, WAIT);
  - a `rr_next(ptr, n)` wrap function;
  - the common `AWIDTH` default.
- Sub-module `rr_pick`: combinational round-robin priority picker.
  - Inputs: `req`, `ptr`.
  - Outputs: `winner` index, `any`.
  - It is reusable for a future write-request arbiter.
- The top level contains the FSM, the address/id registers, the watchdog counter and `ptr`.

## Test plan
- **Single request:** `SRC_NUM`=2, `req`=01, `addr0`=0x1000, `m_arready`=1.
  - Expect `rd_en`=01 for 1 cycle, `m_araddr`=0x1000, `m_arid`=0.
  - `rd_done` 4 cycles later → IDLE, `ptr`=1.
- **Round-robin fairness:** `SRC_NUM`=4, `req`=1111 held, immediate `rd_done`.
  - Expect grant order 0,1,2,3,0.
  - `req`=1001 with `ptr`=1 → source 3 then 0.
- **Backpressure:** `m_arready` low for 5 cycles.
  - Expect `m_arvalid`, `m_araddr`, `m_arid` stable for all 5 cycles.
  - Expect a single `rd_en` pulse.
  - WAIT is entered the cycle after `m_arready`=1.
- **Timeout:** `TIMEOUT`=8, no `rd_done`.
  - Expect `timeout_err` pulse 8 cycles after accept, state IDLE, `ptr` advanced.
  - `rd_done` on the 8th cycle instead → no error.
- **Reset mid-WAIT:** `areset` for 1 cycle.
  - Expect all outputs 0 and `ptr`=0 at the next edge.
  - A later `rd_done` is ignored.
  - Next `req`=10 → grant source 1.
- **Stray completion:** `rd_done` asserted in IDLE and ISSUE → no state change and no `ptr` change.

Source files
------------

// File: rtl/xbar_pkg.sv
// Shared cross-bar definitions: arbiter state encoding, round-robin wrap
// helper and the common address width default.
package xbar_pkg;

    localparam int XBAR_AWIDTH = 32;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_e;

    // Next round-robin position after ptr, wrapping n-1 back to 0.
    function automatic int rr_next(input int ptr, input int n);
        int nxt;
        if (ptr >= (n - 32'sd1)) begin
            nxt = 32'sd0;
        end else begin
            nxt = ptr + 32'sd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority picker: returns the first set request
// at or above ptr, wrapping modulo N. Shared by read and write arbiters.
module rr_pick #(
    parameter int N   = 2,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [IDW-1:0] winner,
    output logic           any
);

    // Scan from the farthest candidate down to ptr so the nearest one wins.
    always_comb begin
        int idx;
        winner = '0;
        idx    = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx    = (int'(ptr) + k) % N;
            winner = req[idx] ? IDW'(idx) : winner;
        end
        any = |req;
    end

endmodule

// File: rtl/rd_req_arbiter.sv
// Round-robin read-address arbiter: pops one request from the winning
// first-word-fall-through FIFO, issues it downstream with its source tag and
// holds the channel until the read completes or the watchdog expires.
module rd_req_arbiter
    import xbar_pkg::*;
#(
    parameter int AWIDTH  = XBAR_AWIDTH,
    parameter int SRC_NUM = 2,
    parameter int IDW     = $clog2(SRC_NUM),
    parameter int TIMEOUT = 256
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [SRC_NUM-1:0]        req,
    input  logic [SRC_NUM*AWIDTH-1:0] addr,
    output logic [SRC_NUM-1:0]        rd_en,
    output logic                      m_arvalid,
    output logic [AWIDTH-1:0]         m_araddr,
    output logic [IDW-1:0]            m_arid,
    input  logic                      m_arready,
    input  logic                      rd_done,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_e          state_r, state_s;
    logic [IDW-1:0]      ptr_r, ptr_s;
    logic [CW-1:0]       cnt_r, cnt_s;
    logic [SRC_NUM-1:0]  rd_en_r, rd_en_s;
    logic                m_arvalid_r, m_arvalid_s;
    logic [AWIDTH-1:0]   m_araddr_r, m_araddr_s;
    logic [IDW-1:0]      m_arid_r, m_arid_s;
    logic                busy_r, busy_s;
    logic                timeout_err_r, timeout_err_s;
    logic [IDW-1:0]      winner_s;
    logic                any_s;
    logic [AWIDTH-1:0]   head_addr_s;
    logic [SRC_NUM-1:0]  winner_onehot_s;
    logic [IDW-1:0]      ptr_adv_s;

    rr_pick #(
        .N   (SRC_NUM),
        .IDW (IDW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_r),
        .winner (winner_s),
        .any    (any_s)
    );

    // Select the winner's head address and build its one-hot pop strobe.
    always_comb begin
        head_addr_s     = '0;
        winner_onehot_s = '0;
        for (int i = 0; i < SRC_NUM; i++) begin
            head_addr_s        = (winner_s == IDW'(i)) ? addr[i*AWIDTH +: AWIDTH] : head_addr_s;
            winner_onehot_s[i] = (winner_s == IDW'(i));
        end
        ptr_adv_s = IDW'(rr_next(int'(m_arid_r), SRC_NUM));
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_s       = state_r;
        ptr_s         = ptr_r;
        cnt_s         = cnt_r;
        rd_en_s       = '0;
        m_arvalid_s   = 1'b0;
        m_araddr_s    = m_araddr_r;
        m_arid_s      = m_arid_r;
        timeout_err_s = 1'b0;
        case (state_r)
            ARB_IDLE: begin
                if (any_s) begin
                    m_arid_s    = winner_s;
                    m_araddr_s  = head_addr_s;
                    rd_en_s     = winner_onehot_s;
                    m_arvalid_s = 1'b1;
                    state_s     = ARB_ISSUE;
                end else begin
                    state_s = ARB_IDLE;
                end
            end
            ARB_ISSUE: begin
                if (m_arvalid_r && m_arready) begin
                    cnt_s   = '0;
                    state_s = ARB_WAIT;
                end else begin
                    m_arvalid_s = 1'b1;
                end
            end
            ARB_WAIT: begin
                if (rd_done) begin
                    ptr_s   = ptr_adv_s;
                    state_s = ARB_IDLE;
                end else if (cnt_r == CW'(TIMEOUT - 1)) begin
                    timeout_err_s = 1'b1;
                    ptr_s         = ptr_adv_s;
                    state_s       = ARB_IDLE;
                end else begin
                    // Saturating increment: the count never wraps.
                    cnt_s = (cnt_r == {CW{1'b1}}) ? cnt_r : (cnt_r + CW'(1));
                end
            end
            default: begin
                state_s = ARB_IDLE;
            end
        endcase
        busy_s = (state_s != ARB_IDLE);
    end

    // State, pointer, watchdog and output registers with synchronous reset.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r       <= ARB_IDLE;
            ptr_r         <= '0;
            cnt_r         <= '0;
            rd_en_r       <= '0;
            m_arvalid_r   <= 1'b0;
            m_araddr_r    <= '0;
            m_arid_r      <= '0;
            busy_r        <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            ptr_r         <= ptr_s;
            cnt_r         <= cnt_s;
            rd_en_r       <= rd_en_s;
            m_arvalid_r   <= m_arvalid_s;
            m_araddr_r    <= m_araddr_s;
            m_arid_r      <= m_arid_s;
            busy_r        <= busy_s;
            timeout_err_r <= timeout_err_s;
        end
    end

    assign rd_en       = rd_en_r;
    assign m_arvalid   = m_arvalid_r;
    assign m_araddr    = m_araddr_r;
    assign m_arid      = m_arid_r;
    assign busy        = busy_r;
    assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_rd_req_arbiter.sv
// Self-checking bench for rd_req_arbiter: directed scenarios followed by
// randomized grants, all predicted by a transaction-level round-robin model.
module tb_rd_req_arbiter;

    localparam int AW = 32;
    localparam int N  = 4;
    localparam int IW = 2;
    localparam int TO = 8;

    logic          aclk = 1'b0;
    logic          areset;
    logic [N-1:0]  req;
    logic [N*AW-1:0] addr;
    logic [N-1:0]  rd_en;
    logic          m_arvalid;
    logic [AW-1:0] m_araddr;
    logic [IW-1:0] m_arid;
    logic          m_arready;
    logic          rd_done;
    logic          busy;
    logic          timeout_err;

    int checks = 0;
    int errors = 0;
    int mptr   = 0;   // model round-robin pointer
    int id;
    int exp_order [5] = '{0, 1, 2, 3, 0};

    rd_req_arbiter #(
        .AWIDTH  (AW),
        .SRC_NUM (N),
        .IDW     (IW),
        .TIMEOUT (TO)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .req         (req),
        .addr        (addr),
        .rd_en       (rd_en),
        .m_arvalid   (m_arvalid),
        .m_araddr    (m_araddr),
        .m_arid      (m_arid),
        .m_arready   (m_arready),
        .rd_done     (rd_done),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    // Free-running clock.
    always #5 aclk = ~aclk;

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference round-robin: first requester at or after p, modulo N.
    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic rand_addr();
        for (int i = 0; i < N; i++) addr[i*AW +: AW] = $urandom;
    endtask

    // One complete grant. lat==0 means no rd_done (watchdog expiry),
    // otherwise rd_done arrives in the lat-th WAIT cycle. bp = cycles of
    // backpressure, stray = rd_done held high while in ISSUE, gap = add one
    // idle cycle with no request afterwards.
    task automatic grant(input logic [N-1:0] rq, input int bp, input int lat,
                         input bit stray, input bit gap, output int gid);
        int w;
        logic [AW-1:0] ea;
        w  = pick(rq, mptr);
        ea = addr[w*AW +: AW];
        req = rq; m_arready = 1'b0; rd_done = stray;
        step();
        gid = int'(m_arid);
        chk("pop", rd_en, 64'(1) << w);
        chk("arvalid", m_arvalid, 1);
        chk("araddr", m_araddr, ea);
        chk("arid", m_arid, w);
        chk("busy_issue", busy, 1);
        req = 4'($urandom);
        for (int i = 0; i < bp; i++) begin
            step();
            chk("hold_valid", m_arvalid, 1);
            chk("hold_addr", m_araddr, ea);
            chk("hold_id", m_arid, w);
            chk("single_pop", rd_en, 0);
        end
        m_arready = 1'b1;
        step();
        m_arready = 1'b0; rd_done = 1'b0;
        chk("accept_valid", m_arvalid, 0);
        chk("accept_busy", busy, 1);
        chk("accept_pop", rd_en, 0);
        if (lat == 0) begin
            for (int i = 1; i < TO; i++) begin
                step();
                chk("wait_busy", busy, 1);
                chk("no_early_tmo", timeout_err, 0);
            end
            step();
            chk("tmo_pulse", timeout_err, 1);
            chk("tmo_idle", busy, 0);
        end else begin
            for (int i = 1; i < lat; i++) begin
                step();
                chk("wait_busy", busy, 1);
            end
            rd_done = 1'b1;
            step();
            rd_done = 1'b0;
            chk("done_idle", busy, 0);
            chk("done_no_tmo", timeout_err, 0);
        end
        mptr = (w + 1) % N;
        req = '0;
        if (gap) begin
            step();
            chk("idle_valid", m_arvalid, 0);
            chk("idle_pop", rd_en, 0);
            chk("idle_tmo", timeout_err, 0);
            chk("idle_busy", busy, 0);
        end
    endtask

    initial begin
        areset = 1'b1; req = '0; addr = '0; m_arready = 1'b0; rd_done = 1'b0;
        step();
        chk("rst_pop", rd_en, 0);
        chk("rst_valid", m_arvalid, 0);
        chk("rst_addr", m_araddr, 0);
        chk("rst_id", m_arid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tmo", timeout_err, 0);
        step();
        areset = 1'b0;
        mptr = 0;

        // Single request, completion 4 cycles into WAIT.
        rand_addr();
        addr[0 +: AW] = 32'h0000_1000;
        grant(4'b0001, 0, 4, 1'b0, 1'b1, id);
        chk("single_id", id, 0);
        // Pointer moved to 1: with sources 0 and 1 pending, 1 wins.
        rand_addr();
        grant(4'b0011, 0, 2, 1'b0, 1'b1, id);
        chk("ptr_after_single", id, 1);
        grant(4'b1000, 0, 1, 1'b0, 1'b1, id);
        chk("wrap_to_3", id, 3);

        // Fairness with all requesting and back-to-back grants.
        for (int g = 0; g < 5; g++) begin
            rand_addr();
            grant(4'b1111, 0, 1, 1'b0, 1'b0, id);
            chk("rr_order", id, exp_order[g]);
        end
        grant(4'b1001, 0, 1, 1'b0, 1'b0, id);
        chk("rr_1001_first", id, 3);
        grant(4'b1001, 0, 1, 1'b0, 1'b1, id);
        chk("rr_1001_second", id, 0);

        // Backpressure, watchdog expiry, completion on the last allowed cycle.
        rand_addr();
        grant(4'b0110, 5, 3, 1'b0, 1'b1, id);
        grant(4'b1111, 0, 0, 1'b0, 1'b1, id);
        grant(4'b1111, 2, TO, 1'b0, 1'b1, id);

        // Stray completions in IDLE and ISSUE.
        rd_done = 1'b1; req = '0;
        step();
        step();
        chk("stray_idle_busy", busy, 0);
        chk("stray_idle_valid", m_arvalid, 0);
        rand_addr();
        grant(4'b1111, 3, 2, 1'b1, 1'b1, id);
        grant(4'b1111, 0, 2, 1'b0, 1'b1, id);

        // Reset in the middle of WAIT.
        rand_addr();
        req = 4'b0100; m_arready = 1'b1;
        step();
        step();
        req = '0; m_arready = 1'b0;
        step();
        areset = 1'b1;
        step();
        areset = 1'b0;
        mptr = 0;
        chk("mid_rst_pop", rd_en, 0);
        chk("mid_rst_valid", m_arvalid, 0);
        chk("mid_rst_addr", m_araddr, 0);
        chk("mid_rst_id", m_arid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_tmo", timeout_err, 0);
        rd_done = 1'b1;
        step();
        rd_done = 1'b0;
        chk("late_done_busy", busy, 0);
        chk("late_done_pop", rd_en, 0);
        for (int i = 0; i < TO + 2; i++) begin
            step();
            chk("no_stale_tmo", timeout_err, 0);
        end
        rand_addr();
        grant(4'b0010, 0, 1, 1'b0, 1'b1, id);
        chk("post_rst_grant", id, 1);

        // Randomized grants against the model.
        for (int t = 0; t < 40; t++) begin
            logic [N-1:0] rq;
            int lat;
            rq  = 4'($urandom_range(1, 15));
            lat = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, TO));
            rand_addr();
            grant(rq, int'($urandom_range(0, 3)), lat, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), id);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
